// File: rtl/aim_frame_filter_if.sv
// Signal bundle between the tracker/mode-mux side and the frame filter.
// master drives the raw tracker results, slave is the filter itself.
interface aim_frame_filter_if;
  logic       v_sync;
  logic [9:0] x_in;
  logic [9:0] y_in;
  logic       detect_in;
  logic       shoot_in;
  logic [9:0] x_out;
  logic [9:0] y_out;
  logic       detect_out;
  logic       shoot_out;
  logic       frame_valid;
  logic [1:0] state_out;

  modport master (
    output v_sync, x_in, y_in, detect_in, shoot_in,
    input  x_out, y_out, detect_out, shoot_out, frame_valid, state_out
  );

  modport slave (
    input  v_sync, x_in, y_in, detect_in, shoot_in,
    output x_out, y_out, detect_out, shoot_out, frame_valid, state_out
  );
endinterface

// File: rtl/aim_frame_filter.sv
// Once-per-frame conditioner for tracker aim data: acquisition, loss coasting,
// first-order smoothing with jump snap, and shoot qualification.
module aim_frame_filter #(
  parameter int unsigned ACQ_FRAMES   = 3,
  parameter int unsigned HOLD_FRAMES  = 8,
  parameter int unsigned ALPHA_SHIFT  = 2,
  parameter logic [9:0]  JUMP_THR     = 10'd80,
  parameter int unsigned SHOOT_FRAMES = 2,
  parameter logic [9:0]  X_MAX        = 10'd639,
  parameter logic [9:0]  Y_MAX        = 10'd479
) (
  input  logic              clk,
  input  logic              reset,
  aim_frame_filter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACQ   = 2'd1,
    ST_TRACK = 2'd2,
    ST_COAST = 2'd3
  } state_e;

  localparam logic [9:0] X_CENTER = 10'd320;
  localparam logic [9:0] Y_CENTER = 10'd240;

  function automatic logic [9:0] clamp_axis(input logic [9:0] v, input logic [9:0] lim);
    logic [9:0] r;
    if (v > lim) begin
      r = lim;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Arithmetic shift floors toward -inf, so small negative deltas still step by -1.
  function automatic logic [9:0] smooth_axis(input logic [9:0] in_c, input logic [9:0] cur,
                                             input logic [9:0] lim);
    logic signed [10:0] delta;
    logic signed [10:0] step;
    logic        [10:0] mag;
    logic signed [11:0] sum;
    logic        [9:0]  r;
    delta = $signed({1'b0, in_c}) - $signed({1'b0, cur});
    step  = delta >>> ALPHA_SHIFT;
    mag   = delta[10] ? (11'd0 - delta) : delta;
    sum   = $signed({2'b00, cur}) + $signed({step[10], step});
    if (mag > {1'b0, JUMP_THR}) begin
      r = in_c;
    end else if (sum < 12'sd0) begin
      r = 10'd0;
    end else if (sum > $signed({2'b00, lim})) begin
      r = lim;
    end else begin
      r = sum[9:0];
    end
    return r;
  endfunction

  state_e     state_q, state_d;
  logic [7:0] acq_cnt_q, acq_cnt_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [7:0] shoot_cnt_q, shoot_cnt_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       detect_q, detect_d;
  logic       shoot_q, shoot_d;
  logic       v_sync_q;
  logic       upd_q;
  logic       frame_valid_q;

  logic       tick_s;
  logic [9:0] x_clamp_s, y_clamp_s;
  logic [9:0] x_smooth_s, y_smooth_s;

  assign tick_s     = v_sync_q & ~bus.v_sync;
  assign x_clamp_s  = clamp_axis(bus.x_in, X_MAX);
  assign y_clamp_s  = clamp_axis(bus.y_in, Y_MAX);
  assign x_smooth_s = smooth_axis(x_clamp_s, x_q, X_MAX);
  assign y_smooth_s = smooth_axis(y_clamp_s, y_q, Y_MAX);

  // Per-frame state machine and output computation; everything holds between ticks.
  always_comb begin
    state_d     = state_q;
    acq_cnt_d   = acq_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    shoot_cnt_d = shoot_cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    detect_d    = detect_q;
    shoot_d     = shoot_q;
    if (tick_s) begin
      shoot_cnt_d = 8'd0;
      case (state_q)
        ST_IDLE: begin
          hold_cnt_d = 8'd0;
          if (bus.detect_in) begin
            if (ACQ_FRAMES <= 1) begin
              state_d   = ST_TRACK;
              acq_cnt_d = 8'd0;
              x_d       = x_clamp_s;
              y_d       = y_clamp_s;
            end else begin
              state_d   = ST_ACQ;
              acq_cnt_d = 8'd1;
            end
          end else begin
            acq_cnt_d = 8'd0;
          end
        end
        ST_ACQ: begin
          if (bus.detect_in) begin
            if ((acq_cnt_q + 8'd1) == 8'(ACQ_FRAMES)) begin
              state_d   = ST_TRACK;
              acq_cnt_d = 8'd0;
              x_d       = x_clamp_s;
              y_d       = y_clamp_s;
            end else begin
              acq_cnt_d = acq_cnt_q + 8'd1;
            end
          end else begin
            state_d   = ST_IDLE;
            acq_cnt_d = 8'd0;
          end
        end
        ST_TRACK: begin
          if (bus.detect_in) begin
            x_d = x_smooth_s;
            y_d = y_smooth_s;
            if (bus.shoot_in) begin
              if (shoot_cnt_q < 8'(SHOOT_FRAMES)) begin
                shoot_cnt_d = shoot_cnt_q + 8'd1;
              end else begin
                shoot_cnt_d = shoot_cnt_q;
              end
            end else begin
              shoot_cnt_d = 8'd0;
            end
          end else if (HOLD_FRAMES <= 1) begin
            state_d    = ST_IDLE;
            hold_cnt_d = 8'd0;
            x_d        = X_CENTER;
            y_d        = Y_CENTER;
          end else begin
            state_d    = ST_COAST;
            hold_cnt_d = 8'd1;
          end
        end
        ST_COAST: begin
          if (bus.detect_in) begin
            state_d    = ST_TRACK;
            hold_cnt_d = 8'd0;
            x_d        = x_smooth_s;
            y_d        = y_smooth_s;
          end else if ((hold_cnt_q + 8'd1) == 8'(HOLD_FRAMES)) begin
            state_d    = ST_IDLE;
            hold_cnt_d = 8'd0;
            x_d        = X_CENTER;
            y_d        = Y_CENTER;
          end else begin
            hold_cnt_d = hold_cnt_q + 8'd1;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          acq_cnt_d  = 8'd0;
          hold_cnt_d = 8'd0;
          x_d        = X_CENTER;
          y_d        = Y_CENTER;
        end
      endcase
      detect_d = (state_d == ST_TRACK) || (state_d == ST_COAST);
      shoot_d  = (state_d == ST_TRACK) && (shoot_cnt_d == 8'(SHOOT_FRAMES));
    end else begin
      state_d = state_q;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      acq_cnt_q     <= 8'd0;
      hold_cnt_q    <= 8'd0;
      shoot_cnt_q   <= 8'd0;
      x_q           <= X_CENTER;
      y_q           <= Y_CENTER;
      detect_q      <= 1'b0;
      shoot_q       <= 1'b0;
      v_sync_q      <= 1'b1;
      upd_q         <= 1'b0;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      acq_cnt_q     <= acq_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      shoot_cnt_q   <= shoot_cnt_d;
      x_q           <= x_d;
      y_q           <= y_d;
      detect_q      <= detect_d;
      shoot_q       <= shoot_d;
      v_sync_q      <= bus.v_sync;
      upd_q         <= tick_s;
      frame_valid_q <= upd_q;
    end
  end

  assign bus.x_out       = x_q;
  assign bus.y_out       = y_q;
  assign bus.detect_out  = detect_q;
  assign bus.shoot_out   = shoot_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.state_out   = state_q;

endmodule
